// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// pc_sequencer_pkg : shared branch codes, sequencer states and next-PC selects
// Revision 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JUMP = 3'b111
    } br_op_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } seq_state_e;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_ALU = 2'b01;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_branch_resolve.sv
// ============================================================================
// branch_resolve : combinational branch/jump decision from ALU compare flags
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_resolve
    import pc_sequencer_pkg::*;
(
    input  logic [2:0] branchOp_i,
    input  logic       aluZero_i,
    input  logic       aluLt_i,
    input  logic       aluLtu_i,
    output logic       taken_o
);

    br_op_e w_op;

    always_comb begin
        w_op    = br_op_e'(branchOp_i);
        taken_o = 1'b0;
        case (w_op)
            BR_NONE: taken_o = 1'b0;
            BR_BEQ:  taken_o = aluZero_i;
            BR_BNE:  taken_o = ~aluZero_i;
            BR_BLT:  taken_o = aluLt_i;
            BR_BGE:  taken_o = ~aluLt_i;
            BR_BLTU: taken_o = aluLtu_i;
            BR_BGEU: taken_o = ~aluLtu_i;
            BR_JUMP: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : PC owner, fetch/exec/update sequencing, retire counter, trap
// Revision 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [2:0]      branchOp,
    input  logic            aluZero,
    input  logic            aluLt,
    input  logic            aluLtu,
    input  logic            exDone,
    input  logic [XLEN-1:0] nextPcIn,
    output logic [1:0]      NexPcSrc,
    output logic [XLEN-1:0] pc,
    output logic            instrFire,
    output logic [XLEN-1:0] instret,
    output logic            misalignErr,
    output logic            halted
);

    localparam logic [XLEN-1:0] c_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic            err_q, err_d;
    logic            fire_q, fire_d;
    logic            active_q;
    logic            w_taken;

    branch_resolve u_branch_resolve (
        .branchOp_i (branchOp),
        .aluZero_i  (aluZero),
        .aluLt_i    (aluLt),
        .aluLtu_i   (aluLtu),
        .taken_o    (w_taken)
    );

    // active_q holds the fetch request off for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC[XLEN-1:0];
            instret_q <= '0;
            err_q     <= 1'b0;
            fire_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            err_q     <= err_d;
            fire_q    <= fire_d;
            active_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        err_d     = err_q;
        fire_d    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (active_q && imemAck) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exDone) begin
                    if (!is_word_aligned(nextPcIn[1:0])) begin
                        state_d = ST_HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d      = nextPcIn;
                        fire_d    = 1'b1;
                        instret_d = instret_q + c_ONE;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    assign imemReq     = active_q && (state_q == ST_FETCH);
    assign imemAddr    = pc_q;
    assign NexPcSrc    = ((state_q == ST_EXEC) && w_taken) ? NPC_ALU : NPC_SEQ;
    assign pc          = pc_q;
    assign instrFire   = fire_q;
    assign instret     = instret_q;
    assign misalignErr = err_q;
    assign halted      = (state_q == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : directed + random stimulus against a behavioural model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imemReq, imemAck = 1'b0;
    logic [31:0] imemAddr;
    logic [2:0]  branchOp = 3'b000;
    logic        aluZero = 1'b0, aluLt = 1'b0, aluLtu = 1'b0, exDone = 1'b0;
    logic [31:0] nextPcIn = '0;
    logic [1:0]  NexPcSrc;
    logic [31:0] pc, instret;
    logic        instrFire, misalignErr, halted;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = fetching, 1 = executing, 2 = halted.
    int          m_phase;
    bit          m_active, m_err, m_fire;
    logic [31:0] m_pc, m_instret;
    logic [31:0] cur_a, cur_b;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemAck(imemAck), .branchOp(branchOp), .aluZero(aluZero), .aluLt(aluLt),
        .aluLtu(aluLtu), .exDone(exDone), .nextPcIn(nextPcIn), .NexPcSrc(NexPcSrc),
        .pc(pc), .instrFire(instrFire), .instret(instret),
        .misalignErr(misalignErr), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd1: return a == b;
            3'd2: return a != b;
            3'd3: return $signed(a) < $signed(b);
            3'd4: return $signed(a) >= $signed(b);
            3'd5: return a < b;
            3'd6: return a >= b;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all();
        chk("imemReq", 32'(imemReq), 32'(m_active && m_phase == 0));
        chk("imemAddr", imemAddr, m_pc);
        chk("pc", pc, m_pc);
        chk("NexPcSrc", 32'(NexPcSrc),
            32'((m_phase == 1 && exp_taken(branchOp, cur_a, cur_b)) ? 2'b01 : 2'b00));
        chk("instrFire", 32'(instrFire), 32'(m_fire));
        chk("instret", instret, m_instret);
        chk("misalignErr", 32'(misalignErr), 32'(m_err));
        chk("halted", 32'(halted), 32'(m_phase == 2));
    endtask

    task automatic model_reset();
        m_phase = 0; m_active = 0; m_err = 0; m_fire = 0;
        m_pc = RESET_PC; m_instret = 0;
    endtask

    // Called just after a negedge; ends just after the following negedge.
    task automatic cyc(input bit ack, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit exd, input logic [31:0] npc);
        imemAck = ack; branchOp = op; exDone = exd; nextPcIn = npc;
        cur_a = a; cur_b = b;
        aluZero = ((a - b) == 32'd0);
        aluLt   = ($signed(a) < $signed(b));
        aluLtu  = (a < b);
        #1;
        check_all();
        @(posedge clk);
        m_fire = 0;
        if (m_phase == 0 && m_active && ack) begin
            m_phase = 1;
        end else if (m_phase == 1 && exd) begin
            if (npc % 4 != 0) begin
                m_phase = 2; m_err = 1;
            end else begin
                m_pc = npc; m_fire = 1; m_instret = m_instret + 1; m_phase = 0;
            end
        end
        m_active = 1;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle, checks asynchronous clearing, releases on a negedge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit reset_mid_exec_done;
        int halt_cycles;
        model_reset();
        cur_a = 0; cur_b = 0;
        @(negedge clk);
        do_reset();

        // Out of reset: no request in the first cycle, then request at RESET_PC.
        cyc(0, 3'd0, 0, 0, 0, 0);
        cyc(0, 3'd0, 0, 0, 0, 0);
        chk("req_after_reset", 32'(imemReq), 32'd1);

        // Sequential instruction.
        cyc(1, 3'd0, 0, 0, 0, 0);
        cyc(0, 3'd0, 5, 5, 1, 32'h4);
        chk("seq_fire", 32'(instrFire), 32'd1);
        chk("seq_pc", pc, 32'h4);

        // BNE taken, then BNE not taken.
        cyc(1, 3'd0, 0, 0, 0, 0);
        cyc(0, 3'd2, 1, 2, 1, 32'h40);
        cyc(1, 3'd0, 0, 0, 0, 0);
        chk("bne_pc", pc, 32'h40);
        cyc(0, 3'd2, 7, 7, 0, 0);
        cyc(0, 3'd2, 7, 7, 1, 32'h44);

        // Stalled fetch with stray exDone pulses.
        for (int i = 0; i < 5; i++) cyc(0, 3'd7, 0, 1, i[0], 32'h80);
        chk("stall_addr", imemAddr, 32'h44);

        // Misaligned jump target traps into HALT.
        cyc(1, 3'd0, 0, 0, 1, 32'h8);
        cyc(0, 3'd7, 0, 0, 1, 32'h42);
        for (int i = 0; i < 3; i++) cyc(1, 3'd7, 0, 0, 1, 32'h48);
        chk("halt_pc", pc, 32'h44);
        chk("halt_instret", instret, 32'd3);

        do_reset();

        // Random traffic; reset on halt and once mid-execution.
        reset_mid_exec_done = 0;
        halt_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b, npc;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            npc = {32'($urandom) >> 2, 2'b00};
            if ($urandom_range(0, 19) == 0) npc[1:0] = 2'($urandom_range(1, 3));
            if (m_phase == 2) halt_cycles++;
            if (halt_cycles > 3 || (i >= 300 && !reset_mid_exec_done && m_phase == 1)) begin
                if (m_phase == 1) reset_mid_exec_done = 1;
                halt_cycles = 0;
                do_reset();
            end
            cyc($urandom_range(0, 1), 3'($urandom), a, b, $urandom_range(0, 2) == 0, npc);
        end
        chk("mid_exec_reset_seen", 32'(reset_mid_exec_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
